// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit adder/subtractor with carry/borrow-in.
// The carry chain is cut into CHUNK-bit slices, one register stage per slice,
// so the longest combinational path is a single CHUNK-bit ripple.
// A valid/ready stream interface with a single global enable provides
// back-pressure without a skid buffer.
// Optional build macro: ADDSUB_SAT_EN -- saturate o_sum on signed overflow.
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int MSB    = WIDTH - 1;

    // Pipeline enable: the whole pipe moves unless a result is stuck at the output.
    logic en_s;

    // Effective operands at the pipe entry (B and carry inverted for subtract).
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;

    // Per-stage registers. Operands travel full-width alongside each beat so
    // later stages can pick their chunk; the result word fills in chunk by chunk.
    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] cry_r;
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  res_r [STAGES];
    logic              ovf_r;

    // Next-state values for every stage.
    logic [STAGES-1:0] vld_nx_s;
    logic [STAGES-1:0] cry_nx_s;
    logic [WIDTH-1:0]  a_nx_s   [STAGES];
    logic [WIDTH-1:0]  b_nx_s   [STAGES];
    logic [WIDTH-1:0]  res_nx_s [STAGES];
    logic              ovf_nx_s;

    // Stall control and entry operand conditioning.
    always_comb begin
        en_s    = (!vld_r[STAGES-1]) || i_ready;
        b_eff_s = i_b ^ {WIDTH{i_sub}};
        c_eff_s = i_c ^ i_sub;
    end

    // Per-stage chunk add, final-stage overflow and optional saturation.
    always_comb begin
        logic [WIDTH-1:0] src_a_s;
        logic [WIDTH-1:0] src_b_s;
        logic [WIDTH-1:0] src_res_s;
        logic             src_c_s;
        logic             src_v_s;
        logic [CHUNK:0]   part_s;
        logic [WIDTH-1:0] last_a_s;
        logic [WIDTH-1:0] last_b_s;
        int               j;

        src_a_s   = {WIDTH{1'b0}};
        src_b_s   = {WIDTH{1'b0}};
        src_res_s = {WIDTH{1'b0}};
        src_c_s   = 1'b0;
        src_v_s   = 1'b0;
        part_s    = {(CHUNK+1){1'b0}};
        last_a_s  = {WIDTH{1'b0}};
        last_b_s  = {WIDTH{1'b0}};
        j         = 0;
        vld_nx_s  = {STAGES{1'b0}};
        cry_nx_s  = {STAGES{1'b0}};
        ovf_nx_s  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            a_nx_s[k]   = {WIDTH{1'b0}};
            b_nx_s[k]   = {WIDTH{1'b0}};
            res_nx_s[k] = {WIDTH{1'b0}};
        end

        for (int k = 0; k < STAGES; k++) begin
            j = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                src_a_s   = i_a;
                src_b_s   = b_eff_s;
                src_c_s   = c_eff_s;
                src_res_s = {WIDTH{1'b0}};
                src_v_s   = i_valid;
            end else begin
                src_a_s   = a_r[j];
                src_b_s   = b_r[j];
                src_c_s   = cry_r[j];
                src_res_s = res_r[j];
                src_v_s   = vld_r[j];
            end
            part_s = {1'b0, src_a_s[k*CHUNK +: CHUNK]}
                   + {1'b0, src_b_s[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_c_s};
            res_nx_s[k]                  = src_res_s;
            res_nx_s[k][k*CHUNK +: CHUNK] = part_s[CHUNK-1:0];
            cry_nx_s[k] = part_s[CHUNK];
            a_nx_s[k]   = src_a_s;
            b_nx_s[k]   = src_b_s;
            vld_nx_s[k] = src_v_s;
            last_a_s    = src_a_s;
            last_b_s    = src_b_s;
        end

        // Carry into the MSB is recovered as a^b^sum at that bit.
        ovf_nx_s = last_a_s[MSB] ^ last_b_s[MSB]
                 ^ res_nx_s[STAGES-1][MSB] ^ cry_nx_s[STAGES-1];

`ifdef ADDSUB_SAT_EN
        // Clamp toward the sign of A when the signed result overflows.
        if (ovf_nx_s) begin
            if (last_a_s[MSB]) begin
                res_nx_s[STAGES-1] = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res_nx_s[STAGES-1] = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res_nx_s[STAGES-1] = res_nx_s[STAGES-1];
        end
`endif
    end

    // Pipeline registers: async clear, shift all stages together when enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_r <= {STAGES{1'b0}};
            cry_r <= {STAGES{1'b0}};
            ovf_r <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                res_r[k] <= {WIDTH{1'b0}};
            end
        end else if (en_s) begin
            vld_r <= vld_nx_s;
            cry_r <= cry_nx_s;
            ovf_r <= ovf_nx_s;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= a_nx_s[k];
                b_r[k]   <= b_nx_s[k];
                res_r[k] <= res_nx_s[k];
            end
        end
    end

    // Outputs come straight from the final stage registers.
    always_comb begin
        o_ready = en_s;
        o_valid = vld_r[STAGES-1];
        o_sum   = res_r[STAGES-1];
        o_carry = cry_r[STAGES-1];
        o_ovf   = ovf_r;
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe at WIDTH=8, CHUNK=4 (two stages).
module tb_addsub_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       ds_ready;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;

    int vectors;
    int miscompares;

    addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_a     (a),
        .i_b     (b),
        .i_c     (cin),
        .i_sub   (sub),
        .o_valid (out_valid),
        .i_ready (ds_ready),
        .o_sum   (sum),
        .o_carry (carry),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one beat, scramble the inputs after acceptance, check latency and result.
    task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic vs, input logic [7:0] es, input logic ec,
                         input logic eo, input string tag);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; ds_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, {15'd0, out_ready}, 16'd1);
        tick();
        in_valid = 1'b0; a = ~va; b = ~vb; cin = ~vc; sub = ~vs;
        #1;
        chk({tag, "_early"}, {15'd0, out_valid}, 16'd0);
        tick();
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_sum"},   {8'd0, sum},        {8'd0, es});
        chk({tag, "_carry"}, {15'd0, carry},     {15'd0, ec});
        chk({tag, "_ovf"},   {15'd0, ovf},       {15'd0, eo});
    endtask

    initial begin
        int sent;
        int got;
        int stall_left;
        int done_cyc;
        logic first_seen;
        logic stalled;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0; in_valid = 1'b0; ds_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;

        // Reset state.
        #3;
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_sum",   {8'd0, sum},        16'd0);
        chk("rst_carry", {15'd0, carry},     16'd0);
        chk("rst_ovf",   {15'd0, ovf},       16'd0);
        chk("rst_ready", {15'd0, out_ready}, 16'd1);
        #9 rst_n = 1'b1;
        tick();

        // Single-beat directed vectors.
        issue(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, "add_small");
`ifdef ADDSUB_SAT_EN
        issue(8'hAA, 8'hBB, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, "add_ovf");
        issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, "sub_ovf");
        issue(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, "sub_ovf_pos");
`else
        issue(8'hAA, 8'hBB, 1'b0, 1'b0, 8'h65, 1'b1, 1'b1, "add_ovf");
        issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");
        issue(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "sub_ovf_pos");
`endif
        issue(8'h05, 8'h09, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, "sub_borrow");
        issue(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, "cin_chunk");
        issue(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "sub_bin");
        issue(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
        tick();
        tick();

        // Streaming with back-pressure: 6 beats (n, 15-n), stall 3 cycles after first result.
        sent = 0; got = 0; stall_left = 0; done_cyc = -1; first_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            stalled  = (stall_left > 0);
            ds_ready = !stalled;
            if (sent < 6) begin
                in_valid = 1'b1; a = 8'(sent); b = 8'(15 - sent); cin = 1'b0; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                chk("bp_ready_low",   {15'd0, out_ready}, 16'd0);
                chk("bp_valid_held",  {15'd0, out_valid}, 16'd1);
                chk("bp_sum_held",    {8'd0, sum},        16'h000F);
            end
            if (out_valid && ds_ready) begin
                chk("bp_sum",   {8'd0, sum},    16'h000F);
                chk("bp_carry", {15'd0, carry}, 16'd0);
                got++;
                if (got == 6) done_cyc = cyc;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    stall_left = 4;
                end
            end
            if (in_valid && out_ready) sent++;
            if (stall_left > 0) stall_left--;
            tick();
        end
        in_valid = 1'b0; ds_ready = 1'b1;
        chk("bp_results", 16'(got),      16'd6);
        chk("bp_sent",    16'(sent),     16'd6);
        chk("bp_cycles",  16'(done_cyc), 16'd10);
        #1;
        chk("bp_no_dup", {15'd0, out_valid}, 16'd0);
        tick();
        chk("bp_drained", {15'd0, out_valid}, 16'd0);

        // Reset mid-stream with two beats in flight.
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'h03; b = 8'h04;
        tick();
        in_valid = 1'b0;
        chk("mid_inflight", {15'd0, out_valid}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_sum",   {8'd0, sum},        16'd0);
        chk("mid_rst_carry", {15'd0, carry},     16'd0);
        chk("mid_rst_ovf",   {15'd0, ovf},       16'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", {15'd0, out_ready}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", {15'd0, out_valid}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
